// File: rtl/io_pkg.sv
// Shared constants for the MMIO input peripheral: default window base and register offsets.
package io_pkg;

    localparam logic [31:0] IO_BASE_ADDR = 32'h0000_7800;
    localparam logic [31:0] IO_WIN_SIZE  = 32'h0000_0020;

    localparam logic [4:0] OFS_SW       = 5'h00;
    localparam logic [4:0] OFS_BTN      = 5'h10;
    localparam logic [4:0] OFS_BTN_EDGE = 5'h14;

endpackage

// File: rtl/btn_debounce.sv
// Per-button debouncer: accepts a new synchronized level only after it holds for
// DEBOUNCE_CYC consecutive cycles; o_rise pulses in the cycle the accepted level rises.
module btn_debounce #(
    parameter int DEBOUNCE_CYC = 16
) (
    input  logic clk,
    input  logic rstn,
    input  logic i_s,
    output logic o_q,
    output logic o_rise
);

    localparam int CW = (DEBOUNCE_CYC > 1) ? $clog2(DEBOUNCE_CYC) : 1;
    localparam logic [CW-1:0] TERM = CW'(DEBOUNCE_CYC - 1);

    logic [CW-1:0] cnt;
    logic          q;
    logic          accept;

    assign accept = (i_s != q) && (cnt == TERM);
    assign o_q    = q;
    assign o_rise = accept & i_s;

    // Any return to the accepted level restarts the window; the counter stops at TERM.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            q   <= 1'b0;
            cnt <= '0;
        end else if (i_s == q) begin
            cnt <= '0;
        end else if (accept) begin
            q   <= i_s;
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/io_input_ctrl.sv
// MMIO input peripheral: synchronized switches, debounced buttons with W1C press-event
// capture, and a zero-wait combinational read port on the LSU load/store path.
module io_input_ctrl
    import io_pkg::*;
#(
    parameter int          SW_W         = 32,
    parameter int          BTN_W        = 4,
    parameter int          DEBOUNCE_CYC = 16,
    parameter bit          BTN_ACT_LOW  = 1'b1,
    parameter logic [31:0] BASE_ADDR    = IO_BASE_ADDR
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic [SW_W-1:0]  i_io_sw,
    input  logic [BTN_W-1:0] i_io_btn,
    input  logic [31:0]      i_addr,
    input  logic [31:0]      i_wdata,
    input  logic             i_we,
    output logic [31:0]      o_rdata,
    output logic             o_hit,
    output logic             o_btn_evt
);

    // Raw pin level meaning "not pressed"; the button synchronizer resets to it so a
    // held button must re-qualify through the full pin-to-level latency after reset.
    localparam logic [BTN_W-1:0] BTN_IDLE = {BTN_W{BTN_ACT_LOW}};

    logic [SW_W-1:0]  sw_meta, sw_sync;
    logic [BTN_W-1:0] btn_meta, btn_raw, btn_s;
    logic [BTN_W-1:0] btn_q, btn_rise;
    logic [BTN_W-1:0] edge_q, edge_clr, edge_nxt;
    logic [31:0]      ofs;
    logic             edge_wr;

    // NOTE: non-blocking assignments let each flop sample the previous stage's old value.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            sw_meta  <= '0;
            sw_sync  <= '0;
            btn_meta <= BTN_IDLE;
            btn_raw  <= BTN_IDLE;
        end else begin
            sw_meta  <= i_io_sw;
            sw_sync  <= sw_meta;
            btn_meta <= i_io_btn;
            btn_raw  <= btn_meta;
        end
    end

    assign btn_s = BTN_ACT_LOW ? ~btn_raw : btn_raw;

    for (genvar i = 0; i < BTN_W; i++) begin : g_btn
        btn_debounce #(
            .DEBOUNCE_CYC (DEBOUNCE_CYC)
        ) u_btn_debounce (
            .clk    (clk),
            .rstn   (rstn),
            .i_s    (btn_s[i]),
            .o_q    (btn_q[i]),
            .o_rise (btn_rise[i])
        );
    end

    assign ofs     = i_addr - BASE_ADDR;
    assign o_hit   = (ofs < IO_WIN_SIZE);
    assign edge_wr = i_we && o_hit && (ofs[4:2] == OFS_BTN_EDGE[4:2]);

    // A rise in the same cycle as its clear is kept so no press is lost.
    assign edge_clr = edge_wr ? i_wdata[BTN_W-1:0] : '0;
    assign edge_nxt = (edge_q & ~edge_clr) | btn_rise;

    always_ff @(posedge clk) begin
        if (!rstn) begin
            edge_q    <= '0;
            o_btn_evt <= 1'b0;
        end else begin
            edge_q    <= edge_nxt;
            o_btn_evt <= |edge_q;
        end
    end

    // NOTE: default assigned first so every path drives o_rdata and no latch is inferred.
    always_comb begin
        o_rdata = '0;
        if (o_hit) begin
            case (ofs[4:2])
                OFS_SW[4:2]:       o_rdata = 32'(sw_sync);
                OFS_BTN[4:2]:      o_rdata = 32'(btn_q);
                OFS_BTN_EDGE[4:2]: o_rdata = 32'(edge_q);
                default:           o_rdata = '0;
            endcase
        end
    end

    // Byte-lane bits and upper store-data bits have no meaning for this block.
    logic unused_ok;
    assign unused_ok = &{1'b0, ofs[1:0], i_wdata};

endmodule

// File: tb/tb_io_input_ctrl.sv
// Directed scoreboard bench for io_input_ctrl with DEBOUNCE_CYC=4 and active-low buttons.
module tb_io_input_ctrl;

    localparam int DCYC = 4;

    logic        clk = 1'b0;
    logic        rstn;
    logic [31:0] i_io_sw;
    logic [3:0]  i_io_btn;
    logic [31:0] i_addr;
    logic [31:0] i_wdata;
    logic        i_we;
    logic [31:0] o_rdata;
    logic        o_hit;
    logic        o_btn_evt;

    always #5 clk = ~clk;

    io_input_ctrl #(
        .SW_W         (32),
        .BTN_W        (4),
        .DEBOUNCE_CYC (DCYC),
        .BTN_ACT_LOW  (1'b1),
        .BASE_ADDR    (32'h0000_7800)
    ) dut (
        .clk       (clk),
        .rstn      (rstn),
        .i_io_sw   (i_io_sw),
        .i_io_btn  (i_io_btn),
        .i_addr    (i_addr),
        .i_wdata   (i_wdata),
        .i_we      (i_we),
        .o_rdata   (o_rdata),
        .o_hit     (o_hit),
        .o_btn_evt (o_btn_evt)
    );

    typedef struct {
        string       tag;
        logic [31:0] val;
    } exp_t;

    exp_t sb[$];
    int   n_run  = 0;
    int   n_fail = 0;

    task automatic push(input string tag, input logic [31:0] val);
        exp_t e;
        e.tag = tag;
        e.val = val;
        sb.push_back(e);
    endtask

    task automatic pop_chk(input logic [31:0] obs);
        exp_t e;
        n_run++;
        if (sb.size() == 0) begin
            n_fail++;
            $error("FAIL sb_empty: observed %h, no expectation queued", obs);
        end else begin
            e = sb.pop_front();
            assert (obs === e.val)
            else begin
                n_fail++;
                $error("FAIL %s: observed %h required %h", e.tag, obs, e.val);
            end
        end
    endtask

    task automatic clocks(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic rd(input logic [31:0] a);
        i_addr = a;
        #1;
        pop_chk(o_rdata);
    endtask

    task automatic hit(input logic [31:0] a);
        i_addr = a;
        #1;
        pop_chk({31'b0, o_hit});
    endtask

    task automatic evt();
        pop_chk({31'b0, o_btn_evt});
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d);
        i_addr  = a;
        i_wdata = d;
        i_we    = 1'b1;
        clocks(1);
        i_we    = 1'b0;
        i_wdata = '0;
    endtask

    initial begin
        rstn     = 1'b0;
        i_io_sw  = '0;
        i_io_btn = 4'h0;
        i_addr   = '0;
        i_wdata  = '0;
        i_we     = 1'b0;

        // Reset with all buttons held
        clocks(4);
        push("rst_lvl", 32'h0);  rd(32'h7810);
        push("rst_edge", 32'h0); rd(32'h7814);
        push("rst_evt", 32'h0);  evt();
        push("rst_sw", 32'h0);   rd(32'h7800);
        i_io_btn = 4'hF;
        rstn     = 1'b1;
        clocks(3);
        push("idle_lvl", 32'h0);  rd(32'h7810);
        push("idle_edge", 32'h0); rd(32'h7814);

        // Switch synchronizer latency
        i_io_sw = 32'hA5A5_0F0F;
        push("sw_t1", 32'h0);
        push("sw_t2", 32'hA5A5_0F0F);
        push("sw_t3", 32'hA5A5_0F0F);
        clocks(1); rd(32'h7800);
        clocks(1); rd(32'h7800);
        clocks(1); rd(32'h7800);

        // Clean press on btn0: level and edge appear exactly 2+DCYC clocks later
        i_io_btn = 4'hE;
        for (int i = 1; i < DCYC + 2; i++) begin
            clocks(1);
            push($sformatf("b0_wait%0d", i), 32'h0);
            rd(32'h7810);
        end
        clocks(1);
        push("b0_lvl", 32'h1);    rd(32'h7810);
        push("b0_edge", 32'h1);   rd(32'h7814);
        push("b0_evt_lag", 32'h0); evt();
        clocks(1);
        push("b0_evt", 32'h1);    evt();

        // Release keeps the edge bit
        i_io_btn = 4'hF;
        clocks(DCYC + 3);
        push("b0_rel_lvl", 32'h0);  rd(32'h7810);
        push("b0_rel_edge", 32'h1); rd(32'h7814);

        // W1C clear, event output follows one clock later
        wr(32'h7814, 32'h1);
        push("clr_edge", 32'h0);    rd(32'h7814);
        push("clr_evt_lag", 32'h1); evt();
        clocks(1);
        push("clr_evt", 32'h0);     evt();

        // Bouncy btn1: 3 pressed, 1 released, 10 pressed
        i_io_btn = 4'hD;
        for (int i = 0; i < 3; i++) begin
            clocks(1);
            push($sformatf("b1_bnc_a%0d", i), 32'h0);
            rd(32'h7810);
        end
        i_io_btn = 4'hF;
        clocks(1);
        push("b1_bnc_gap", 32'h0); rd(32'h7810);
        i_io_btn = 4'hD;
        for (int i = 0; i < DCYC + 1; i++) begin
            clocks(1);
            push($sformatf("b1_bnc_b%0d", i), 32'h0);
            rd(32'h7810);
        end
        clocks(1);
        push("b1_lvl", 32'h2);  rd(32'h7810);
        push("b1_edge", 32'h2); rd(32'h7814);
        clocks(4);
        push("b1_hold_lvl", 32'h2);  rd(32'h7810);
        push("b1_hold_edge", 32'h2); rd(32'h7814);
        i_io_btn = 4'hF;
        clocks(DCYC + 3);
        push("b1_rel_lvl", 32'h0);  rd(32'h7810);
        push("b1_rel_edge", 32'h2); rd(32'h7814);

        // Build edge=3, then clear bit0 only
        i_io_btn = 4'hE;
        clocks(DCYC + 2);
        push("e3_edge", 32'h3); rd(32'h7814);
        i_io_btn = 4'hF;
        clocks(DCYC + 3);
        wr(32'h7814, 32'h1);
        push("w1c_edge", 32'h2); rd(32'h7814);
        push("w1c_evt", 32'h1);  evt();

        // New rise on bit0 in the same cycle as its clear: set wins
        i_io_btn = 4'hE;
        clocks(DCYC + 1);
        wr(32'h7814, 32'h1);
        push("setwin_edge", 32'h3); rd(32'h7814);
        push("setwin_lvl", 32'h1);  rd(32'h7810);
        wr(32'h7814, 32'h3);
        push("clrall_edge", 32'h0);    rd(32'h7814);
        push("clrall_evt_lag", 32'h1); evt();
        clocks(1);
        push("clrall_evt", 32'h0);     evt();
        i_io_btn = 4'hF;
        clocks(DCYC + 3);

        // Decode boundaries
        push("rd_7804", 32'h0);  rd(32'h7804);
        push("hit_7804", 32'h1); hit(32'h7804);
        push("rd_781c", 32'h0);  rd(32'h781C);
        push("hit_781c", 32'h1); hit(32'h781C);
        push("rd_7020", 32'h0);  rd(32'h7020);
        push("hit_7020", 32'h0); hit(32'h7020);
        push("hit_7820", 32'h0); hit(32'h7820);
        push("hit_77fc", 32'h0); hit(32'h77FC);
        push("rd_7802", 32'hA5A5_0F0F); rd(32'h7802);

        // Stores outside the edge register have no side effect
        i_io_btn = 4'hB;
        clocks(DCYC + 2);
        wr(32'h7800, 32'hFFFF_FFFF);
        wr(32'h7810, 32'hFFFF_FFFF);
        wr(32'h7818, 32'hFFFF_FFFF);
        wr(32'h7020, 32'hFFFF_FFFF);
        push("st_sw", 32'hA5A5_0F0F); rd(32'h7800);
        push("st_lvl", 32'h4);        rd(32'h7810);
        push("st_edge", 32'h4);       rd(32'h7814);
        push("st_evt", 32'h1);        evt();

        // Byte offset within the edge word still selects it
        wr(32'h7816, 32'h4);
        push("st_7816_edge", 32'h0); rd(32'h7814);

        if (sb.size() != 0) begin
            n_run++;
            n_fail++;
            $error("FAIL sb_leftover: observed %0d queued, required 0", sb.size());
        end

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
